// File: rtl/jml_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : jml_i2c_target
// Purpose  : System-clock-synchronous I2C target bridging onto the register
//            bus, with glitch filtering and a non-incrementing hold window.
// Revision : 1.0 - initial release
// ============================================================================
module jml_i2c_target #(
    parameter logic [6:0] I2C_ADDR  = 7'h10,
    parameter int         AW        = 6,
    parameter int         HOLD_BASE = 'h30,
    parameter int         FILT      = 3
) (
    input  logic          clk,
    input  logic          i2c_resetS_n,
    input  logic          scl,
    input  logic          sda,
    output logic          sda_drv_lo,
    output logic [AW-1:0] addr,
    output logic          read,
    output logic          write,
    output logic [7:0]    write_data,
    input  logic [7:0]    read_data,
    output logic          rd_pop,
    output logic          hold_rd_reset,
    output logic          busy
);

    localparam logic [8:0] c_hold_base = HOLD_BASE[8:0];

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DEV_ADDR = 4'd1,
        S_DEV_ACK  = 4'd2,
        S_REG_ADDR = 4'd3,
        S_REG_ACK  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8,
        S_WAIT     = 4'd9
    } state_t;

    logic [1:0] w_pin;
    logic [1:0] w_filt;

    assign w_pin = {scl, sda};

    // Bit 1 is SCL, bit 0 is SDA; both idle high so reset never fakes an edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic       r_sync1;
        logic       r_sync2;
        logic       r_lvl;
        logic [2:0] r_cnt;

        always_ff @(posedge clk or negedge i2c_resetS_n) begin
            if (!i2c_resetS_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_lvl   <= 1'b1;
                r_cnt   <= 3'd0;
            end else begin
                r_sync1 <= w_pin[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_lvl) begin
                    r_cnt <= 3'd0;
                end else if (r_cnt == 3'(FILT - 1)) begin
                    r_lvl <= r_sync2;
                    r_cnt <= 3'd0;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end

        assign w_filt[gi] = r_lvl;
    end

    logic       w_scl;
    logic       w_sda;
    logic       r_scl_d;
    logic       r_sda_d;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;
    logic       w_addr_lt_hold;
    logic       w_new_in_hold;

    state_t     r_state;
    logic [6:0] r_shift;
    logic [3:0] r_bit_cnt;
    logic       r_rw;
    logic       r_ack_drv;
    logic       r_ack_ok;
    logic       r_load;
    logic       r_inc;

    assign w_scl          = w_filt[1];
    assign w_sda          = w_filt[0];
    assign w_scl_rise     = w_scl & ~r_scl_d;
    assign w_scl_fall     = ~w_scl & r_scl_d;
    assign w_start        = ~w_sda & r_sda_d & w_scl;
    assign w_stop         = w_sda & ~r_sda_d & w_scl;
    assign w_byte         = {r_shift, w_sda};
    assign w_addr_lt_hold = (9'(addr) < c_hold_base);
    assign w_new_in_hold  = (9'(w_byte[AW-1:0]) >= c_hold_base);

    always_ff @(posedge clk or negedge i2c_resetS_n) begin
        if (!i2c_resetS_n) begin
            r_scl_d       <= 1'b1;
            r_sda_d       <= 1'b1;
            r_state       <= S_IDLE;
            r_shift       <= 7'd0;
            r_bit_cnt     <= 4'd0;
            r_rw          <= 1'b0;
            r_ack_drv     <= 1'b0;
            r_ack_ok      <= 1'b0;
            r_load        <= 1'b0;
            r_inc         <= 1'b0;
            sda_drv_lo    <= 1'b0;
            addr          <= '0;
            read          <= 1'b0;
            write         <= 1'b0;
            write_data    <= 8'd0;
            rd_pop        <= 1'b0;
            hold_rd_reset <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_scl_d       <= w_scl;
            r_sda_d       <= w_sda;
            read          <= 1'b0;
            write         <= 1'b0;
            rd_pop        <= 1'b0;
            hold_rd_reset <= 1'b0;
            r_load        <= 1'b0;
            r_inc         <= 1'b0;

            if (r_inc && w_addr_lt_hold) begin
                addr <= addr + AW'(1);
            end
            // read_data is valid in the clk that read is high; MSB goes out now.
            if (r_load) begin
                r_shift    <= read_data[6:0];
                sda_drv_lo <= ~read_data[7];
                r_bit_cnt  <= 4'd0;
            end

            if (w_stop) begin
                r_state    <= S_IDLE;
                sda_drv_lo <= 1'b0;
                r_ack_drv  <= 1'b0;
                r_ack_ok   <= 1'b0;
                busy       <= 1'b0;
            end else if (w_start) begin
                r_state    <= S_DEV_ADDR;
                r_bit_cnt  <= 4'd0;
                sda_drv_lo <= 1'b0;
                r_ack_drv  <= 1'b0;
                r_ack_ok   <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (r_state)
                    S_DEV_ADDR: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (w_byte[7:1] == I2C_ADDR) begin
                                r_state <= S_DEV_ACK;
                                r_rw    <= w_byte[0];
                            end else begin
                                r_state <= S_WAIT;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    S_REG_ADDR: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            addr          <= w_byte[AW-1:0];
                            hold_rd_reset <= w_new_in_hold;
                            r_state       <= S_REG_ACK;
                        end
                    end
                    S_WR_DATA: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            write_data <= w_byte;
                            write      <= 1'b1;
                            r_inc      <= 1'b1;
                            r_state    <= S_WR_ACK;
                        end
                    end
                    // First fall after the 8th bit starts the ACK, the next one ends it.
                    S_DEV_ACK, S_REG_ACK, S_WR_ACK: if (w_scl_fall) begin
                        if (!r_ack_drv) begin
                            sda_drv_lo <= 1'b1;
                            r_ack_drv  <= 1'b1;
                        end else begin
                            sda_drv_lo <= 1'b0;
                            r_ack_drv  <= 1'b0;
                            r_bit_cnt  <= 4'd0;
                            if (r_state == S_DEV_ACK && r_rw) begin
                                r_state <= S_RD_DATA;
                                read    <= 1'b1;
                                r_load  <= 1'b1;
                            end else if (r_state == S_DEV_ACK) begin
                                r_state <= S_REG_ADDR;
                            end else begin
                                r_state <= S_WR_DATA;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                sda_drv_lo <= 1'b0;
                                r_ack_ok   <= 1'b0;
                                r_state    <= S_RD_ACK;
                            end else begin
                                sda_drv_lo <= ~r_shift[6];
                                r_shift    <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_ack_ok <= 1'b1;
                                if (w_addr_lt_hold) begin
                                    addr <= addr + AW'(1);
                                end else begin
                                    rd_pop <= 1'b1;
                                end
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end else if (w_scl_fall && r_ack_ok) begin
                            r_ack_ok <= 1'b0;
                            read     <= 1'b1;
                            r_load   <= 1'b1;
                            r_state  <= S_RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jml_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_jml_i2c_target
// Purpose  : Directed bus-level bench for jml_i2c_target (I2C master model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jml_i2c_target;

    typedef struct {
        logic [7:0] reg_byte;
        logic [7:0] data;
        logic [5:0] exp_wr_addr;
        logic [5:0] exp_final;
        int         exp_hold;
    } wvec_t;

    logic       clk = 1'b0;
    logic       i2c_resetS_n;
    logic       scl_m;
    logic       m_sda_lo;
    logic       sda_line;
    logic       sda_drv_lo;
    logic [5:0] addr;
    logic       read;
    logic       write;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       rd_pop;
    logic       hold_rd_reset;
    logic       busy;

    always #5 clk = ~clk;

    assign sda_line  = ~(m_sda_lo | sda_drv_lo);
    assign read_data = {2'b00, addr} + 8'h40;

    jml_i2c_target #(
        .I2C_ADDR (7'h10),
        .AW       (6),
        .HOLD_BASE('h30),
        .FILT     (3)
    ) dut (
        .clk          (clk),
        .i2c_resetS_n (i2c_resetS_n),
        .scl          (scl_m),
        .sda          (sda_line),
        .sda_drv_lo   (sda_drv_lo),
        .addr         (addr),
        .read         (read),
        .write        (write),
        .write_data   (write_data),
        .read_data    (read_data),
        .rd_pop       (rd_pop),
        .hold_rd_reset(hold_rd_reset),
        .busy         (busy)
    );

    int          n_wr   = 0;
    int          n_rd   = 0;
    int          n_pop  = 0;
    int          n_hold = 0;
    int          n_excl = 0;
    logic [13:0] wr_log [64];

    always @(negedge clk) begin
        if (write) begin
            wr_log[n_wr[5:0]] <= {addr, write_data};
            n_wr <= n_wr + 1;
        end
        if (read)          n_rd   <= n_rd + 1;
        if (rd_pop)        n_pop  <= n_pop + 1;
        if (hold_rd_reset) n_hold <= n_hold + 1;
        if (3'(read) + 3'(write) + 3'(rd_pop) + 3'(hold_rd_reset) > 3'd1) n_excl <= n_excl + 1;
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bit_w(input logic b, input logic glitch);
        if (glitch) begin
            #40 scl_m = 1'b1;
            #20 scl_m = 1'b0;
            #40;
        end else begin
            #100;
        end
        m_sda_lo = ~b;
        #100 scl_m = 1'b1;
        #200 scl_m = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, input int gbit, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(b[i], i == gbit);
        #100 m_sda_lo = 1'b0;
        #100 scl_m = 1'b1;
        #100 ack = ~sda_line;
        #100 scl_m = 1'b0;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            #100 m_sda_lo = 1'b0;
            #100 scl_m = 1'b1;
            #100 b[i] = sda_line;
            #100 scl_m = 1'b0;
        end
        #100 m_sda_lo = ack;
        #100 scl_m = 1'b1;
        #200 scl_m = 1'b0;
    endtask

    // Works from idle and as a repeated START from a low SCL.
    task automatic start_c;
        #100 m_sda_lo = 1'b0;
        #100 scl_m = 1'b1;
        #100 m_sda_lo = 1'b1;
        #100 scl_m = 1'b0;
    endtask

    task automatic stop_c;
        #100 m_sda_lo = 1'b1;
        #100 scl_m = 1'b1;
        #100 m_sda_lo = 1'b0;
        #200;
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wvec_t      vt [5];
        logic       a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, d3;
        int         b_wr, b_rd, b_pop, b_hold;

        vt[0] = '{8'h05, 8'h3C, 6'h05, 6'h06, 0};
        vt[1] = '{8'h2F, 8'h81, 6'h2F, 6'h30, 0};
        vt[2] = '{8'h30, 8'h7E, 6'h30, 6'h30, 1};
        vt[3] = '{8'h3F, 8'hFF, 6'h3F, 6'h3F, 1};
        vt[4] = '{8'hC5, 8'h00, 6'h05, 6'h06, 0};

        i2c_resetS_n = 1'b0;
        scl_m        = 1'b1;
        m_sda_lo     = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_drv_lo", sda_drv_lo, 0);
        check("rst_addr", addr, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {read, write, rd_pop, hold_rd_reset}, 0);
        check("rst_write_data", write_data, 0);
        i2c_resetS_n = 1'b1;
        #200;

        for (int k = 0; k < 5; k++) begin
            b_wr   = n_wr;
            b_hold = n_hold;
            start_c;
            wr_byte(8'h20, -1, a0);
            wr_byte(vt[k].reg_byte, -1, a1);
            wr_byte(vt[k].data, -1, a2);
            stop_c;
            check($sformatf("vec%0d_acks", k), {a0, a1, a2}, 3'b111);
            check($sformatf("vec%0d_wr_cnt", k), n_wr - b_wr, 1);
            check($sformatf("vec%0d_wr_addr", k), wr_log[b_wr[5:0]][13:8], vt[k].exp_wr_addr);
            check($sformatf("vec%0d_wr_data", k), wr_log[b_wr[5:0]][7:0], vt[k].data);
            check($sformatf("vec%0d_final_addr", k), addr, vt[k].exp_final);
            check($sformatf("vec%0d_hold_cnt", k), n_hold - b_hold, vt[k].exp_hold);
            check($sformatf("vec%0d_busy", k), busy, 0);
        end

        // Two-byte write burst.
        b_wr = n_wr;
        start_c;
        wr_byte(8'h20, -1, a0);
        wr_byte(8'h05, -1, a1);
        wr_byte(8'hA1, -1, a2);
        wr_byte(8'hB2, -1, a3);
        stop_c;
        check("burst_acks", {a0, a1, a2, a3}, 4'b1111);
        check("burst_wr_cnt", n_wr - b_wr, 2);
        check("burst_wr0", wr_log[b_wr[5:0]], {6'h05, 8'hA1});
        check("burst_wr1", wr_log[6'(b_wr + 1)], {6'h06, 8'hB2});
        check("burst_final_addr", addr, 7);

        // Auto-incrementing read after repeated START.
        b_rd  = n_rd;
        b_pop = n_pop;
        start_c;
        wr_byte(8'h20, -1, a0);
        wr_byte(8'h10, -1, a1);
        start_c;
        wr_byte(8'h21, -1, a2);
        rd_byte(1'b1, d0);
        rd_byte(1'b1, d1);
        rd_byte(1'b0, d2);
        stop_c;
        check("rd_acks", {a0, a1, a2}, 3'b111);
        check("rd_byte0", d0, 8'h50);
        check("rd_byte1", d1, 8'h51);
        check("rd_byte2", d2, 8'h52);
        check("rd_read_cnt", n_rd - b_rd, 3);
        check("rd_pop_cnt", n_pop - b_pop, 0);
        check("rd_final_addr", addr, 6'h12);
        check("rd_busy", busy, 0);

        // Streaming reads inside the hold window.
        b_rd   = n_rd;
        b_pop  = n_pop;
        b_hold = n_hold;
        start_c;
        wr_byte(8'h20, -1, a0);
        wr_byte(8'h31, -1, a1);
        start_c;
        wr_byte(8'h21, -1, a2);
        rd_byte(1'b1, d0);
        rd_byte(1'b1, d1);
        rd_byte(1'b1, d2);
        rd_byte(1'b0, d3);
        stop_c;
        check("hold_acks", {a0, a1, a2}, 3'b111);
        check("hold_rst_cnt", n_hold - b_hold, 1);
        check("hold_pop_cnt", n_pop - b_pop, 3);
        check("hold_read_cnt", n_rd - b_rd, 4);
        check("hold_addr", addr, 6'h31);
        check("hold_data", {d0, d1, d2, d3}, 32'h71717171);

        // Foreign device address.
        b_wr  = n_wr;
        b_rd  = n_rd;
        b_pop = n_pop;
        b_hold = n_hold;
        start_c;
        wr_byte(8'h44, -1, a0);
        check("wrong_ack", a0, 0);
        check("wrong_busy", busy, 0);
        wr_byte(8'h05, -1, a1);
        check("wrong_ack2", a1, 0);
        stop_c;
        check("wrong_strobes", (n_wr - b_wr) + (n_rd - b_rd) + (n_pop - b_pop) + (n_hold - b_hold), 0);

        // SCL glitches, then a partial byte cut off by STOP.
        b_wr = n_wr;
        start_c;
        wr_byte(8'h20, -1, a0);
        wr_byte(8'h08, -1, a1);
        wr_byte(8'hA5, 3, a2);
        bit_w(1'b1, 1'b0);
        bit_w(1'b0, 1'b1);
        bit_w(1'b1, 1'b0);
        bit_w(1'b1, 1'b0);
        stop_c;
        check("glitch_acks", {a0, a1, a2}, 3'b111);
        check("glitch_wr_cnt", n_wr - b_wr, 1);
        check("glitch_wr", wr_log[b_wr[5:0]], {6'h08, 8'hA5});
        check("glitch_final_addr", addr, 6'h09);
        check("glitch_busy", busy, 0);

        // Reset while the target is driving a 0 data bit.
        b_rd = n_rd;
        start_c;
        wr_byte(8'h20, -1, a0);
        wr_byte(8'h00, -1, a1);
        start_c;
        wr_byte(8'h21, -1, a2);
        #100;
        check("rr_read_cnt", n_rd - b_rd, 1);
        check("rr_drv_before", sda_drv_lo, 1);
        @(negedge clk);
        #2 i2c_resetS_n = 1'b0;
        #1;
        check("rr_drv_after", sda_drv_lo, 0);
        check("rr_outputs", {addr, write_data, busy, read, write, rd_pop, hold_rd_reset}, 0);
        #50 i2c_resetS_n = 1'b1;
        stop_c;
        b_wr = n_wr;
        start_c;
        wr_byte(8'h20, -1, a0);
        wr_byte(8'h0A, -1, a1);
        wr_byte(8'h5C, -1, a2);
        stop_c;
        check("rr_post_acks", {a0, a1, a2}, 3'b111);
        check("rr_post_wr", wr_log[b_wr[5:0]], {6'h0A, 8'h5C});
        check("rr_post_addr", addr, 6'h0B);

        check("strobe_exclusive", n_excl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
